// File: rtl/inv_cipher.sv
// Iterative AES-128/192/256 inverse cipher: one InvCipher round per clock,
// fed by a pre-expanded key schedule.
//   state | meaning
//   IDLE  | waiting for cs; initial AddRoundKey with key[nr] on start
//   RUN   | one inverse round per edge, rnd counts down to 0
//   DONE  | result held in decrypted_msg, flag high until cs drops
module inv_cipher (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [3:0]    nr,
  input  logic [127:0]  init,
  input  logic [1919:0] w,
  output logic [127:0]  decrypted_msg,
  output logic          flag
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_t       state, state_nxt;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [3:0]   nr_eff;
  logic [127:0] key_load, key_rnd, round_out;

  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic         mix);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    // byte index = row + 4*col; row r rotates right by r columns
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        t[rr+4*c] = inv_sub(a[rr + 4*((c - rr + 4) % 4)]) ^ k[127-8*(rr+4*c) -: 8];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < 4; j++) begin
          x2 = xt(t[4*c+j]);
          x4 = xt(x2);
          x8 = xt(x4);
          m9[j] = x8 ^ t[4*c+j];
          mb[j] = x8 ^ x2 ^ t[4*c+j];
          md[j] = x8 ^ x4 ^ t[4*c+j];
          me[j] = x8 ^ x4 ^ x2;
        end
        t[4*c]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        t[4*c+1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        t[4*c+2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        t[4*c+3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  always_comb begin
    nr_eff = 4'd10;
    if (nr == 4'd12 || nr == 4'd14) nr_eff = nr;
  end

  // key i lives at bits [1919-128*i -: 128] == [(14-i)*128 +: 128]
  assign key_load  = w[{4'(4'd14 - nr_eff), 7'd0} +: 128];
  assign key_rnd   = w[{4'(4'd14 - rnd), 7'd0} +: 128];
  assign round_out = inv_round(st, key_rnd, rnd != 4'd0);
  assign flag      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs) state_nxt = RUN;
      RUN:     if (!cs) state_nxt = IDLE;
               else if (rnd == 4'd0) state_nxt = DONE;
      DONE:    if (!cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= '0;
      rnd           <= '0;
      decrypted_msg <= '0;
    end else begin
      case (state)
        IDLE: if (cs) begin
          st  <= init ^ key_load;
          rnd <= nr_eff - 4'd1;
        end
        RUN: if (cs) begin
          st  <= round_out;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd0) decrypted_msg <= round_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: FIPS-197 vectors with bench-side key expansion,
// scoreboard queue checked by a flag-rise monitor.
module tb_inv_cipher;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs;
  logic [3:0]    nr;
  logic [127:0]  init;
  logic [1919:0] w_in;
  logic [127:0]  decrypted_msg;
  logic          flag;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sbox [256];
  logic [1919:0] w128, w192, w256;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  inv_cipher dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .nr(nr), .init(init), .w(w_in),
    .decrypted_msg(decrypted_msg), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] res = '0;
    int            nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = wd[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      wd[i] = wd[i-nk] ^ tmp;
    end
    for (int i = 0; i < nw; i++) res[1919-32*i -: 32] = wd[i];
    return res;
  endfunction

  // monitor: every rising flag must match the oldest queued expectation
  initial begin : monitor
    logic flag_q = 1'b0;
    forever begin
      @(negedge clk);
      if (flag && !flag_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%h required=none", decrypted_msg);
        end else begin
          check("result", decrypted_msg, exp_q.pop_front());
        end
      end
      flag_q = flag;
    end
  end

  // counts edges until flag, checking the output is untouched before completion
  task automatic wait_flag(input string name, input int lat, input logic [127:0] prior);
    int n = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (flag) begin
        n = e;
        break;
      end
      check({name, "_msg_held"}, decrypted_msg, prior);
    end
    check({name, "_latency"}, 128'(n), 128'(lat));
  endtask

  task automatic run(input string name, input logic [127:0] ct, input logic [3:0] nrv,
                     input logic [1919:0] wv, input int lat, input logic [127:0] prior);
    @(negedge clk);
    init = ct;
    nr   = nrv;
    w_in = wv;
    cs   = 1'b1;
    exp_q.push_back(PT);
    wait_flag(name, lat, prior);
  endtask

  task automatic stop_run(input string name);
    @(negedge clk);
    cs = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_flag_clear"}, 128'(flag), 128'(0));
    check({name, "_msg_keep"}, decrypted_msg, PT);
  endtask

  initial begin
    logic [7:0] inv;
    rst_n = 1'b0;
    cs    = 1'b0;
    nr    = 4'd10;
    init  = '0;
    w_in  = '0;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int u = 1; u < 256; u++)
        if (v != 0 && gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      sbox[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    w128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    w192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    w256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    #12;
    check("reset_flag", 128'(flag), 128'(0));
    check("reset_msg", decrypted_msg, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("aes128", CT128, 4'd10, w128, 11, 128'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_flag", 128'(flag), 128'(1));
      check("hold_msg", decrypted_msg, PT);
    end
    stop_run("aes128");

    run("aes192", CT192, 4'd12, w192, 13, PT);
    stop_run("aes192");
    run("aes256", CT256, 4'd14, w256, 15, PT);
    stop_run("aes256");
    run("nr_other", CT128, 4'd0, w128, 11, PT);
    stop_run("nr_other");

    // abort after 5 edges: nothing completes, prior result stays
    @(negedge clk);
    init = CT128;
    nr   = 4'd10;
    w_in = w128;
    cs   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check("abort_flag", 128'(flag), 128'(0));
      check("abort_msg", decrypted_msg, PT);
    end
    run("restart", CT128, 4'd10, w128, 11, PT);
    stop_run("restart");

    // asynchronous reset mid-run, cs kept high through release
    @(negedge clk);
    cs = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_flag", 128'(flag), 128'(0));
    check("areset_msg", decrypted_msg, 128'h0);
    @(negedge clk);
    exp_q.push_back(PT);
    rst_n = 1'b1;
    wait_flag("post_reset", 11, 128'h0);
    stop_run("post_reset");

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
